// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: per-stage enable/flush, PC enable/select, D-cache miss wait and halt drain.
// Optional STALL_CNT_EN macro builds a saturating stall-cycle counter on stall_cnt.
module pipe_hazard_ctrl #(
    parameter int REG_W        = 5,
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             mem_dREN,
    input  logic             mem_dWEN,
    input  logic             mem_halt,
    input  logic             mem_br_taken,
    input  logic             id_jmp,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_memToReg,
    input  logic             ex_WEN,
    input  logic [REG_W-1:0] ex_wsel,
    output logic             pc_en,
    output logic [1:0]       pc_sel,
    output logic             en_ifid,
    output logic             en_idex,
    output logic             en_exmem,
    output logic             en_memwb,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             flush_exmem,
    output logic             halt_out,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

    localparam logic [1:0] PC_SEQ    = 2'd0;
    localparam logic [1:0] PC_JUMP   = 2'd1;
    localparam logic [1:0] PC_BRANCH = 2'd2;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } ctrlState_e;

    ctrlState_e         state;
    ctrlState_e         nextState;
    logic [DRAIN_W-1:0] drainCnt;
    logic [DRAIN_W-1:0] drainCntNext;

    logic dataMiss;
    logic loadUse;

    assign dataMiss = (mem_dREN | mem_dWEN) & ~dhit;

    // A load writing r0 never produces usable data, so it cannot cause a hazard.
    assign loadUse = ex_memToReg & ex_WEN & (ex_wsel != '0) &
                     ((ex_wsel == id_rs) | (id_uses_rt & (ex_wsel == id_rt)));

    always_comb begin
        nextState    = state;
        drainCntNext = drainCnt;
        pc_en        = 1'b0;
        pc_sel       = PC_SEQ;
        en_ifid      = 1'b0;
        en_idex      = 1'b0;
        en_exmem     = 1'b0;
        en_memwb     = 1'b0;
        flush_ifid   = 1'b0;
        flush_idex   = 1'b0;
        flush_exmem  = 1'b0;

        // Everything held low while reset is asserted, regardless of state.
        if (!RST) begin
            unique case (state)
                RUN: begin
                    en_ifid  = 1'b1;
                    en_idex  = 1'b1;
                    en_exmem = 1'b1;
                    en_memwb = 1'b1;
                    pc_en    = ihit;
                    if (dataMiss) begin
                        en_ifid   = 1'b0;
                        en_idex   = 1'b0;
                        en_exmem  = 1'b0;
                        en_memwb  = 1'b0;
                        pc_en     = 1'b0;
                        nextState = DWAIT;
                    end else if (mem_br_taken) begin
                        flush_ifid  = 1'b1;
                        flush_idex  = 1'b1;
                        flush_exmem = 1'b1;
                        pc_en       = 1'b1;
                        pc_sel      = PC_BRANCH;
                    end else if (mem_halt) begin
                        flush_ifid   = 1'b1;
                        flush_idex   = 1'b1;
                        flush_exmem  = 1'b1;
                        pc_en        = 1'b0;
                        nextState    = DRAIN;
                        drainCntNext = '0;
                    end else if (loadUse) begin
                        en_ifid    = 1'b0;
                        pc_en      = 1'b0;
                        flush_idex = 1'b1;
                    end else if (id_jmp) begin
                        flush_ifid = 1'b1;
                        pc_en      = 1'b1;
                        pc_sel     = PC_JUMP;
                    end else if (!ihit) begin
                        pc_en      = 1'b0;
                        flush_ifid = 1'b1;
                    end
                end

                DWAIT: begin
                    // The completing cycle advances like a plain RUN cycle; hazards are re-evaluated next cycle.
                    if (dhit) begin
                        en_ifid   = 1'b1;
                        en_idex   = 1'b1;
                        en_exmem  = 1'b1;
                        en_memwb  = 1'b1;
                        pc_en     = ihit;
                        nextState = RUN;
                    end
                end

                DRAIN: begin
                    en_ifid     = 1'b1;
                    en_idex     = 1'b1;
                    en_exmem    = 1'b1;
                    en_memwb    = 1'b1;
                    flush_ifid  = 1'b1;
                    flush_idex  = 1'b1;
                    flush_exmem = 1'b1;
                    if (drainCnt == DRAIN_LAST) begin
                        nextState    = HALTED;
                        drainCntNext = '0;
                    end else begin
                        drainCntNext = drainCnt + DRAIN_W'(1);
                    end
                end

                HALTED: begin
                    nextState = HALTED;
                end

                default: begin
                    nextState = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= RUN;
            drainCnt <= '0;
            halt_out <= 1'b0;
        end else begin
            state    <= nextState;
            drainCnt <= drainCntNext;
            halt_out <= (nextState == HALTED);
        end
    end

`ifdef STALL_CNT_EN
    logic [CNT_W-1:0] stallCnt;
    logic             countStall;

    assign countStall = ((state == RUN) | (state == DWAIT)) & ~pc_en;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stallCnt <= '0;
        end else if (countStall && (stallCnt != '1)) begin
            stallCnt <= stallCnt + CNT_W'(1);
        end
    end

    assign stall_cnt = stallCnt;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl; control outputs checked as one packed word.
module tb_pipe_hazard_ctrl;
    localparam int REG_W = 5;
    localparam int CNT_W = 32;

    // {pc_en, pc_sel, en_ifid, en_idex, en_exmem, en_memwb, flush_ifid, flush_idex, flush_exmem}
    localparam logic [9:0] C_ZERO   = 10'b0_00_0000_000;
    localparam logic [9:0] C_NORMAL = 10'b1_00_1111_000;
    localparam logic [9:0] C_LDUSE  = 10'b0_00_0111_010;
    localparam logic [9:0] C_BRANCH = 10'b1_10_1111_111;
    localparam logic [9:0] C_HALT   = 10'b0_00_1111_111;
    localparam logic [9:0] C_JUMP   = 10'b1_01_1111_100;
    localparam logic [9:0] C_IMISS  = 10'b0_00_1111_100;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             ihit, dhit, mem_dREN, mem_dWEN, mem_halt, mem_br_taken, id_jmp;
    logic [REG_W-1:0] id_rs, id_rt, ex_wsel;
    logic             id_uses_rt, ex_memToReg, ex_WEN;
    logic             pc_en;
    logic [1:0]       pc_sel;
    logic             en_ifid, en_idex, en_exmem, en_memwb;
    logic             flush_ifid, flush_idex, flush_exmem;
    logic             halt_out;
    logic [CNT_W-1:0] stall_cnt;

    logic [9:0] ctl;
    assign ctl = {pc_en, pc_sel, en_ifid, en_idex, en_exmem, en_memwb,
                  flush_ifid, flush_idex, flush_exmem};

    int checks = 0;
    int passed = 0;

    pipe_hazard_ctrl #(.REG_W(REG_W), .DRAIN_CYCLES(2), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .mem_halt(mem_halt),
        .mem_br_taken(mem_br_taken), .id_jmp(id_jmp),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_memToReg(ex_memToReg), .ex_WEN(ex_WEN), .ex_wsel(ex_wsel),
        .pc_en(pc_en), .pc_sel(pc_sel),
        .en_ifid(en_ifid), .en_idex(en_idex), .en_exmem(en_exmem), .en_memwb(en_memwb),
        .flush_ifid(flush_ifid), .flush_idex(flush_idex), .flush_exmem(flush_exmem),
        .halt_out(halt_out), .stall_cnt(stall_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic idle();
        ihit = 1'b1; dhit = 1'b1; mem_dREN = 1'b0; mem_dWEN = 1'b0;
        mem_halt = 1'b0; mem_br_taken = 1'b0; id_jmp = 1'b0;
        id_rs = '0; id_rt = '0; id_uses_rt = 1'b0;
        ex_memToReg = 1'b0; ex_WEN = 1'b0; ex_wsel = '0;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        idle();
        RST = 1'b1;
        @(negedge CLK);
        checks++; if (ctl !== C_ZERO) $display("FAIL rst_ctl: ctl=%b expected %b", ctl, C_ZERO); else passed++;
        checks++; if (halt_out !== 1'b0) $display("FAIL rst_halt: halt_out=%b expected 0", halt_out); else passed++;
        checks++; if (stall_cnt !== '0) $display("FAIL rst_stall: stall_cnt=%0d expected 0", stall_cnt); else passed++;
        step();
        RST = 1'b0;
        @(negedge CLK);
        checks++; if (ctl !== C_NORMAL) $display("FAIL run_default: ctl=%b expected %b", ctl, C_NORMAL); else passed++;
        checks++; if (halt_out !== 1'b0) $display("FAIL run_halt: halt_out=%b expected 0", halt_out); else passed++;
        step();
    endtask

    task automatic test_load_use();
        idle();
        ex_memToReg = 1'b1; ex_WEN = 1'b1; ex_wsel = 5'd8; id_rs = 5'd8;
        @(negedge CLK);
        checks++; if (ctl !== C_LDUSE) $display("FAIL lu_rs: ctl=%b expected %b", ctl, C_LDUSE); else passed++;
        step();
        @(negedge CLK);
        checks++; if (ctl !== C_LDUSE) $display("FAIL lu_back_to_back: ctl=%b expected %b", ctl, C_LDUSE); else passed++;
        step();
        ex_wsel = 5'd0; id_rs = 5'd0;
        @(negedge CLK);
        checks++; if (ctl !== C_NORMAL) $display("FAIL lu_r0: ctl=%b expected %b", ctl, C_NORMAL); else passed++;
        step();
        ex_wsel = 5'd8; id_rs = 5'd3; id_rt = 5'd8; id_uses_rt = 1'b1;
        @(negedge CLK);
        checks++; if (ctl !== C_LDUSE) $display("FAIL lu_rt: ctl=%b expected %b", ctl, C_LDUSE); else passed++;
        step();
        id_uses_rt = 1'b0;
        @(negedge CLK);
        checks++; if (ctl !== C_NORMAL) $display("FAIL lu_rt_unused: ctl=%b expected %b", ctl, C_NORMAL); else passed++;
        step();
        id_rs = 5'd8; ex_WEN = 1'b0;
        @(negedge CLK);
        checks++; if (ctl !== C_NORMAL) $display("FAIL lu_no_wen: ctl=%b expected %b", ctl, C_NORMAL); else passed++;
        step();
        ex_WEN = 1'b1; ihit = 1'b0;
        @(negedge CLK);
        checks++; if (ctl !== C_LDUSE) $display("FAIL lu_vs_imiss: ctl=%b expected %b", ctl, C_LDUSE); else passed++;
        step();
        idle();
    endtask

    task automatic test_jump_imiss();
        idle();
        id_jmp = 1'b1; ihit = 1'b0;
        @(negedge CLK);
        checks++; if (ctl !== C_JUMP) $display("FAIL jump: ctl=%b expected %b", ctl, C_JUMP); else passed++;
        step();
        id_jmp = 1'b0;
        @(negedge CLK);
        checks++; if (ctl !== C_IMISS) $display("FAIL imiss: ctl=%b expected %b", ctl, C_IMISS); else passed++;
        step();
        idle();
    endtask

    task automatic test_dmiss();
        idle();
        mem_dREN = 1'b1; dhit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            checks++; if (ctl !== C_ZERO) $display("FAIL dmiss_wait%0d: ctl=%b expected %b", i, ctl, C_ZERO); else passed++;
            step();
        end
        dhit = 1'b1;
        @(negedge CLK);
        checks++; if (ctl !== C_NORMAL) $display("FAIL dmiss_done: ctl=%b expected %b", ctl, C_NORMAL); else passed++;
        step();
        // Back in RUN a jump is honoured; a lingering DWAIT would show all-zero here.
        mem_dREN = 1'b0; dhit = 1'b0; id_jmp = 1'b1;
        @(negedge CLK);
        checks++; if (ctl !== C_JUMP) $display("FAIL dmiss_back_run: ctl=%b expected %b", ctl, C_JUMP); else passed++;
        step();
        idle();
        mem_dWEN = 1'b1; dhit = 1'b1;
        @(negedge CLK);
        checks++; if (ctl !== C_NORMAL) $display("FAIL store_hit: ctl=%b expected %b", ctl, C_NORMAL); else passed++;
        step();
        idle();
    endtask

    task automatic test_branch();
        idle();
        mem_br_taken = 1'b1; id_jmp = 1'b1; ihit = 1'b0; mem_halt = 1'b1;
        ex_memToReg = 1'b1; ex_WEN = 1'b1; ex_wsel = 5'd4; id_rs = 5'd4;
        @(negedge CLK);
        checks++; if (ctl !== C_BRANCH) $display("FAIL branch_prio: ctl=%b expected %b", ctl, C_BRANCH); else passed++;
        step();
        idle();
        @(negedge CLK);
        checks++; if (ctl !== C_NORMAL) $display("FAIL branch_stays_run: ctl=%b expected %b", ctl, C_NORMAL); else passed++;
        step();
    endtask

    task automatic test_halt();
        idle();
        mem_halt = 1'b1;
        @(negedge CLK);
        checks++; if (ctl !== C_HALT) $display("FAIL halt_enter: ctl=%b expected %b", ctl, C_HALT); else passed++;
        step();
        mem_halt = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            checks++; if (ctl !== C_HALT) $display("FAIL drain%0d: ctl=%b expected %b", i, ctl, C_HALT); else passed++;
            checks++; if (halt_out !== 1'b0) $display("FAIL drain%0d_halt: halt_out=%b expected 0", i, halt_out); else passed++;
            step();
        end
        @(negedge CLK);
        checks++; if (ctl !== C_ZERO) $display("FAIL halted_ctl: ctl=%b expected %b", ctl, C_ZERO); else passed++;
        checks++; if (halt_out !== 1'b1) $display("FAIL halted_flag: halt_out=%b expected 1", halt_out); else passed++;
        step();
        mem_br_taken = 1'b1; id_jmp = 1'b1;
        step();
        @(negedge CLK);
        checks++; if (ctl !== C_ZERO) $display("FAIL halted_sticky: ctl=%b expected %b", ctl, C_ZERO); else passed++;
        checks++; if (halt_out !== 1'b1) $display("FAIL halted_sticky_flag: halt_out=%b expected 1", halt_out); else passed++;
        #2 RST = 1'b1;
        #1;
        checks++; if (halt_out !== 1'b0) $display("FAIL halted_async_rst: halt_out=%b expected 0", halt_out); else passed++;
        step();
        RST = 1'b0;
        idle();
        step();
    endtask

    task automatic test_reset_mid_drain();
        idle();
        mem_halt = 1'b1;
        step();
        mem_halt = 1'b0;
        @(negedge CLK);
        checks++; if (ctl !== C_HALT) $display("FAIL mid_drain: ctl=%b expected %b", ctl, C_HALT); else passed++;
        #2 RST = 1'b1;
        #1;
        checks++; if (ctl !== C_ZERO) $display("FAIL mid_drain_rst: ctl=%b expected %b", ctl, C_ZERO); else passed++;
        step();
        RST = 1'b0;
        for (int i = 0; i < 3; i++) step();
        @(negedge CLK);
        checks++; if (ctl !== C_NORMAL) $display("FAIL after_drain_rst: ctl=%b expected %b", ctl, C_NORMAL); else passed++;
        checks++; if (halt_out !== 1'b0) $display("FAIL after_drain_halt: halt_out=%b expected 0", halt_out); else passed++;
        step();
    endtask

    task automatic test_stall_cnt();
        logic [CNT_W-1:0] expCnt;
`ifdef STALL_CNT_EN
        expCnt = CNT_W'(5);
`else
        expCnt = '0;
`endif
        idle();
        RST = 1'b1;
        step();
        RST = 1'b0;
        ihit = 1'b0;
        for (int i = 0; i < 5; i++) step();
        ihit = 1'b1;
        @(negedge CLK);
        checks++; if (stall_cnt !== expCnt) $display("FAIL stall_cnt5: stall_cnt=%0d expected %0d", stall_cnt, expCnt); else passed++;
        step();
        @(negedge CLK);
        checks++; if (stall_cnt !== expCnt) $display("FAIL stall_cnt_hold: stall_cnt=%0d expected %0d", stall_cnt, expCnt); else passed++;
        step();
    endtask

    initial begin
        idle();
        test_reset();
        test_load_use();
        test_jump_imiss();
        test_dmiss();
        test_branch();
        test_halt();
        test_reset_mid_drain();
        test_stall_cnt();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
